bcd_xs3_seq_ctrl: RTL and testbench
===================================

BCD_XS3_SEQ_CTRL -- requirements
Module: bcd_xs3_seq_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, giving the number of packed BCD digits per word (legal range 1..8).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port flush, input, 1 bit: synchronous abort; discards any word in flight.
REQ-005 SHALL have port in_valid, input, 1 bit: in_bcd holds a word.
REQ-006 SHALL have port in_ready, output, 1 bit: block can accept a word.
REQ-007 SHALL have port in_bcd, input, 4*NUM_DIGITS bits: packed BCD word, digit 0 in bits [3:0].
REQ-008 SHALL have port out_valid, output, 1 bit: result held on the out_* ports.
REQ-009 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-010 SHALL have port out_xs3, output, 4*NUM_DIGITS bits: packed Excess-3 result, same digit order as in_bcd.
REQ-011 SHALL have port out_err_mask, output, NUM_DIGITS bits: bit i set when input digit i exceeded 9.
REQ-012 SHALL have port out_err, output, 1 bit: OR-reduction of out_err_mask.
REQ-013 SHALL have port busy, output, 1 bit: high in CONV or DONE.

Function
REQ-014 SHALL implement FSM states IDLE, CONV and DONE.
REQ-015 SHALL drive in_ready=1 only in IDLE (no input buffering, no accept during CONV or DONE).
REQ-016 SHALL, in IDLE on in_valid&in_ready, capture in_bcd, clear the result and error registers, set digit index to 0 and enter CONV.
REQ-017 SHALL, in CONV, convert exactly one digit per cycle, LSB digit first, through one shared single-digit converter, writing the result nibble and error bit for index idx.
REQ-018 SHALL map each digit d with 0<=d<=9 to d+3 (4-bit result, no overflow possible).
REQ-019 SHALL map each digit d with 10<=d<=15 to result nibble 4'h0 and set its error bit.
REQ-020 SHALL enter DONE on the cycle digit NUM_DIGITS-1 is written, so that out_valid rises exactly NUM_DIGITS cycles after the accept edge.
REQ-021 SHALL hold out_valid=1 and out_xs3/out_err_mask/out_err stable in DONE until out_valid&out_ready, then return to IDLE.
REQ-022 SHALL drive out_valid=0 outside DONE; out_xs3 and masks keep their last value in IDLE.
REQ-023 SHALL make flush, in any state, force IDLE on the next edge; in DONE with out_ready=1 in the same cycle, flush wins and no transfer is counted.
REQ-024 SHALL ignore flush in IDLE other than keeping IDLE; an in_valid coinciding with flush in IDLE SHALL NOT be accepted.
REQ-025 SHALL reach a minimum word period of NUM_DIGITS+2 cycles (accept, NUM_DIGITS converts, output handshake).

Reset
REQ-026 SHALL on rst_n=0 immediately force state=IDLE, idx=0, out_valid=0, out_xs3=0, out_err_mask=0, out_err=0, busy=0, in_ready=1.
REQ-027 SHALL discard any word in flight on reset mid-CONV or mid-DONE with no partial output.

Structure
REQ-028 SHALL place the FSM state enum, DIGIT_W=4, XS3_OFFSET=3 and BCD_MAX=9 in shared package bcd_xs3_pkg.
REQ-029 SHALL instantiate one combinational sub-module xs3_digit_conv (4-bit digit in, 4-bit result out, err out), shared across all digit slots.

Verification (NUM_DIGITS=4)
REQ-030 SHALL cover: in_bcd=16'h1234 accepted with out_ready=1 -> out_xs3=16'h4567, out_err_mask=4'b0000, out_valid high exactly 4 cycles after the accept edge.
REQ-031 SHALL cover: in_bcd=16'h9870 -> out_xs3=16'hCBA3, out_err=0.
REQ-032 SHALL cover: in_bcd=16'h12A4 -> out_xs3=16'h4507, out_err_mask=4'b0010, out_err=1.
REQ-033 SHALL cover: out_ready held 0 for 5 cycles in DONE -> out_* stable, in_ready=0 throughout; on out_ready=1 the block returns to IDLE and the next word is accepted.
REQ-034 SHALL cover: rst_n pulsed low during the 2nd CONV cycle -> all outputs at reset values immediately, and the next word 16'h0000 yields 16'h3333.
REQ-035 SHALL cover: flush and out_ready both 1 in DONE -> IDLE next cycle, no transfer counted by the scoreboard.

Source files
------------

// File: rtl/bcd_xs3_pkg.sv
// bcd_xs3_pkg: shared FSM states and BCD/Excess-3 constants
package bcd_xs3_pkg;
    localparam int DIGIT_W    = 4;
    localparam int XS3_OFFSET = 3;
    localparam int BCD_MAX    = 9;
    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
endpackage

// File: rtl/xs3_digit_conv.sv
// xs3_digit_conv: single BCD digit to Excess-3, zero result and err for digits above 9
module xs3_digit_conv
    import bcd_xs3_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    output logic [DIGIT_W-1:0] xs3,
    output logic               err
);
    // Illegal BCD digits produce a zero nibble so errors never alias a valid code
    always_comb begin
        err = digit > DIGIT_W'(BCD_MAX);
        xs3 = err ? '0 : digit + DIGIT_W'(XS3_OFFSET);
    end
endmodule

// File: rtl/bcd_xs3_seq_ctrl.sv
// bcd_xs3_seq_ctrl: word-serial BCD to Excess-3 converter, one digit per cycle
module bcd_xs3_seq_ctrl
    import bcd_xs3_pkg::*;
#(
    parameter int NUM_DIGITS = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] in_bcd,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DIGIT_W*NUM_DIGITS-1:0] out_xs3,
    output logic [NUM_DIGITS-1:0]         out_err_mask,
    output logic                          out_err,
    output logic                          busy
);
    localparam int IDX_W = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;

    state_t                          state_q, state_d;
    logic [IDX_W-1:0]                idx;
    logic [DIGIT_W*NUM_DIGITS-1:0]   bcd_q, xs3_q;
    logic [NUM_DIGITS-1:0]           err_q;
    logic [DIGIT_W-1:0]              cur_digit, cur_xs3;
    logic                            cur_err, last, accept;

    assign in_ready     = state_q == IDLE;
    assign out_valid    = state_q == DONE;
    assign busy         = state_q != IDLE;
    assign out_xs3      = xs3_q;
    assign out_err_mask = err_q;
    assign out_err      = |err_q;
    assign last         = idx == IDX_W'(NUM_DIGITS - 1);
    assign accept       = in_valid && in_ready && !flush;
    assign cur_digit    = bcd_q[idx*DIGIT_W +: DIGIT_W];

    xs3_digit_conv u_conv (
        .digit (cur_digit),
        .xs3   (cur_xs3),
        .err   (cur_err)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state: flush overrides everything, including a coincident output handshake
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = accept ? CONV : IDLE;
            CONV:    state_d = last ? DONE : CONV;
            DONE:    state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    // Datapath: capture on accept, then write one converted digit per CONV cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx   <= '0;
            bcd_q <= '0;
            xs3_q <= '0;
            err_q <= '0;
        end else if (flush) begin
            idx <= '0;
        end else if (accept) begin
            idx   <= '0;
            bcd_q <= in_bcd;
            xs3_q <= '0;
            err_q <= '0;
        end else if (state_q == CONV) begin
            xs3_q[idx*DIGIT_W +: DIGIT_W] <= cur_xs3;
            err_q[idx]                    <= cur_err;
            idx                           <= last ? '0 : idx + 1'b1;
        end
    end
endmodule

// File: tb/tb_bcd_xs3_seq_ctrl.sv
// tb_bcd_xs3_seq_ctrl: directed vector bench for the serial BCD to Excess-3 converter
module tb_bcd_xs3_seq_ctrl;
    logic        clk = 0, rst_n, flush, in_valid, in_ready, out_valid, out_ready, out_err, busy;
    logic [15:0] in_bcd, out_xs3;
    logic [3:0]  out_err_mask;
    int          checks = 0, errors = 0, xfers = 0;

    typedef struct {
        logic [15:0] bcd;
        logic [15:0] xs3;
        logic [3:0]  mask;
    } vec_t;
    vec_t vecs[5];

    bcd_xs3_seq_ctrl #(.NUM_DIGITS(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_bcd       (in_bcd),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_xs3      (out_xs3),
        .out_err_mask (out_err_mask),
        .out_err      (out_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Completed output transfers, as seen by a consumer
    always @(posedge clk) if (rst_n && !flush && out_valid && out_ready) xfers <= xfers + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string name);
        chk({name, "_in_ready"}, 32'(in_ready), 1);
        chk({name, "_out_valid"}, 32'(out_valid), 0);
        chk({name, "_busy"}, 32'(busy), 0);
        chk({name, "_xs3"}, 32'(out_xs3), 0);
        chk({name, "_mask"}, 32'(out_err_mask), 0);
        chk({name, "_err"}, 32'(out_err), 0);
    endtask

    // Offer a word, then count edges after the accept edge until out_valid (bounded)
    task automatic send(input logic [15:0] w, output int lat);
        int n = 0;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        chk("accept_ready", 32'(in_ready), 1);
        in_bcd   = w;
        in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
        lat = 0;
        while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    endtask

    initial begin
        int lat, x0;
        logic [15:0] held;
        vecs[0] = '{16'h1234, 16'h4567, 4'b0000};
        vecs[1] = '{16'h9870, 16'hCBA3, 4'b0000};
        vecs[2] = '{16'h12A4, 16'h4507, 4'b0010};
        vecs[3] = '{16'hFFFF, 16'h0000, 4'b1111};
        vecs[4] = '{16'h0999, 16'h3CCC, 4'b0000};
        rst_n = 0; flush = 0; in_valid = 0; out_ready = 1; in_bcd = '0;
        #3;
        chk_reset_vals("reset");
        @(negedge clk); rst_n = 1;

        for (int i = 0; i < 5; i++) begin
            x0 = xfers;
            send(vecs[i].bcd, lat);
            chk($sformatf("v%0d_latency", i), 32'(lat), 4);
            chk($sformatf("v%0d_xs3", i), 32'(out_xs3), 32'(vecs[i].xs3));
            chk($sformatf("v%0d_mask", i), 32'(out_err_mask), 32'(vecs[i].mask));
            chk($sformatf("v%0d_err", i), 32'(out_err), 32'(|vecs[i].mask));
            chk($sformatf("v%0d_busy", i), 32'(busy), 1);
            @(posedge clk); #1;
            chk($sformatf("v%0d_idle", i), 32'(in_ready), 1);
            chk($sformatf("v%0d_xfer", i), 32'(xfers - x0), 1);
        end

        // Back-pressure: DONE must hold its result while out_ready is low
        out_ready = 0;
        x0 = xfers;
        send(16'h0425, lat);
        chk("stall_latency", 32'(lat), 4);
        for (int c = 0; c < 5; c++) begin
            chk("stall_xs3", 32'(out_xs3), 32'h3758);
            chk("stall_valid", 32'(out_valid), 1);
            chk("stall_in_ready", 32'(in_ready), 0);
            @(posedge clk); #1;
        end
        out_ready = 1;
        @(posedge clk); #1;
        chk("stall_release_idle", 32'(in_ready), 1);
        chk("stall_release_valid", 32'(out_valid), 0);
        chk("stall_xfer", 32'(xfers - x0), 1);
        chk("idle_holds_xs3", 32'(out_xs3), 32'h3758);
        send(16'h5678, lat);
        chk("after_stall_latency", 32'(lat), 4);
        chk("after_stall_xs3", 32'(out_xs3), 32'h89AB);
        @(posedge clk); #1;

        // Flush in IDLE blocks a coincident accept
        in_valid = 1; in_bcd = 16'h1111; flush = 1;
        @(posedge clk); #1;
        in_valid = 0; flush = 0;
        chk("flush_idle_ready", 32'(in_ready), 1);
        chk("flush_idle_busy", 32'(busy), 0);

        // Async reset during the second CONV cycle
        in_bcd = 16'h4321; in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
        @(posedge clk); #2;
        rst_n = 0;
        #1;
        chk_reset_vals("midconv_reset");
        @(negedge clk); rst_n = 1;
        send(16'h0000, lat);
        chk("post_reset_latency", 32'(lat), 4);
        chk("post_reset_xs3", 32'(out_xs3), 32'h3333);
        @(posedge clk); #1;

        // Flush wins over out_ready in DONE
        send(16'h2020, lat);
        chk("flush_done_latency", 32'(lat), 4);
        chk("flush_done_xs3", 32'(out_xs3), 32'h5353);
        x0 = xfers;
        flush = 1;
        @(posedge clk); #1;
        flush = 0;
        chk("flush_done_idle", 32'(in_ready), 1);
        chk("flush_done_valid", 32'(out_valid), 0);
        chk("flush_done_no_xfer", 32'(xfers - x0), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
